// File: rtl/bless_pkg.sv
// Shared BLESS router definitions: field widths, control-word layout and the
// injection FSM states. The STARVED state only exists when INJ_STARVE_EN is defined.
package bless_pkg;

  localparam int ADDR_W = 2;
  localparam int SEQ_W  = 3;
  localparam int AGE_W  = 4;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 1 + SEQ_W + 2 * ADDR_W + AGE_W;

  // Control word, MSB first: {valid, seq, src, dest, age}
  localparam int AGE_LSB   = 0;
  localparam int DEST_LSB  = AGE_LSB + AGE_W;
  localparam int SRC_LSB   = DEST_LSB + ADDR_W;
  localparam int SEQ_LSB   = SRC_LSB + ADDR_W;
  localparam int VALID_BIT = SEQ_LSB + SEQ_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } inj_entry_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1
`ifdef INJ_STARVE_EN
    , S_STARVED = 2'd2
`endif
  } inj_state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/inj_fifo.sv
// Synchronous DEPTH-entry FIFO holding flits waiting for injection.
// The head is read straight from storage; there is no empty bypass.
module inj_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage is deliberately not reset; entries are only visible through
  // count/pointers, which are, so clearing the array would add cost for nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/bless_inject_ctrl.sv
// Injection controller for BLESS router port 4: queues node flits, injects when a
// network slot is free, numbers flits and (with INJ_STARVE_EN) flags starvation.
module bless_inject_ctrl
  import bless_pkg::*;
#(
  parameter logic [ADDR_W-1:0] NODE_ADDR  = 2'b00,
  parameter int                DEPTH      = 4,
  parameter int                STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              node_valid,
  output logic              node_ready,
  input  logic [ADDR_W-1:0] node_dest,
  input  logic [DATA_W-1:0] node_data,
  input  logic [3:0]        net_valid_i,
  output logic [CTRL_W-1:0] inj_c,
  output logic [DATA_W-1:0] inj_d,
  output logic              throttle_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_param_check
    $error("bless_inject_ctrl: DEPTH must be a power of two >= 2 and STARVE_MAX >= 1");
  end

  inj_entry_t       push_entry;
  inj_entry_t       head;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             free;
  logic             inject;
  logic             last_pop;
  logic [SEQ_W-1:0] seq_cnt;
  inj_state_t       state;
  inj_state_t       state_next;

  // Held in reset the controller looks idle and swallows nothing.
  assign node_ready = !full || !rst;
  assign push       = node_valid && node_ready && rst;
  assign free       = (popcount4(net_valid_i) < 3'd4);
  assign inject     = rst && !empty && free;
  assign last_pop   = inject && !push && (count == CNT_W'(1));
  assign push_entry = '{dest: node_dest, data: node_data};

  inj_fifo #(
    .WIDTH($bits(inj_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (push_entry),
    .pop  (inject),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches can leave it unassigned and infer a latch.
  always_comb begin
    inj_c = '0;
    inj_d = '0;
    if (inject) begin
      inj_c[VALID_BIT]             = 1'b1;
      inj_c[SEQ_LSB +: SEQ_W]      = seq_cnt;
      inj_c[SRC_LSB +: ADDR_W]     = NODE_ADDR;
      inj_c[DEST_LSB +: ADDR_W]    = head.dest;
      inj_c[AGE_LSB +: AGE_W]      = '0;
      inj_d                        = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)        seq_cnt <= '0;
    else if (inject) seq_cnt <= seq_cnt + SEQ_W'(1);
  end

`ifdef INJ_STARVE_EN
  localparam int              BLK_W   = $clog2(STARVE_MAX + 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(STARVE_MAX);

  logic [BLK_W-1:0] blk_cnt;

  always_ff @(posedge clk) begin
    if (!rst || inject || empty) blk_cnt <= '0;
    else if (!free && blk_cnt != BLK_MAX) blk_cnt <= blk_cnt + BLK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) throttle_o <= 1'b0;
    else      throttle_o <= (state_next == S_STARVED);
  end
`else
  assign throttle_o = 1'b0;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (push) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (last_pop) state_next = S_IDLE;
`ifdef INJ_STARVE_EN
        else if (!inject && blk_cnt == BLK_MAX) state_next = S_STARVED;
`endif
      end
`ifdef INJ_STARVE_EN
      S_STARVED: begin
        if (inject) state_next = last_pop ? S_IDLE : S_WAIT;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// Directed bench for bless_inject_ctrl (NODE_ADDR=2'b10, DEPTH=4, STARVE_MAX=15).
// Throttle expectations follow INJ_STARVE_EN.
module tb_bless_inject_ctrl;
  import bless_pkg::*;

  localparam logic [ADDR_W-1:0] NODE  = 2'b10;
  localparam int                DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              node_valid = 1'b0;
  logic              node_ready;
  logic [ADDR_W-1:0] node_dest = '0;
  logic [DATA_W-1:0] node_data = '0;
  logic [3:0]        net_valid_i = 4'hF;
  logic [CTRL_W-1:0] inj_c;
  logic [DATA_W-1:0] inj_d;
  logic              throttle_o;

  int n_cmp = 0;
  int n_bad = 0;

  bless_inject_ctrl #(
    .NODE_ADDR (NODE),
    .DEPTH     (DEPTH),
    .STARVE_MAX(15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .node_valid (node_valid),
    .node_ready (node_ready),
    .node_dest  (node_dest),
    .node_data  (node_data),
    .net_valid_i(net_valid_i),
    .inj_c      (inj_c),
    .inj_d      (inj_d),
    .throttle_o (throttle_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; checks run 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [CTRL_W-1:0] exp_c(input int seq, input logic [ADDR_W-1:0] dest);
    return {1'b1, 3'(seq), NODE, dest, 4'h0};
  endfunction

  task automatic push_one(input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data);
    node_valid = 1'b1;
    node_dest  = dest;
    node_data  = data;
    tick();
    node_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_ready", node_ready, 1);
    check("rst_inj_c", inj_c, 0);
    check("rst_inj_d", inj_d, 0);
    check("rst_throttle", throttle_o, 0);

    // Single flit, free network: injects the cycle after the push edge
    rst = 1'b1;
    net_valid_i = 4'b0000;
    node_valid = 1'b1;
    node_dest  = 2'd1;
    node_data  = 32'hA5;
    settle();
    check("no_bypass", inj_c, 0);
    tick();
    node_valid = 1'b0;
    settle();
    check("single_c", inj_c, exp_c(0, 2'd1));
    check("single_d", inj_d, 32'hA5);
    tick();
    settle();
    check("single_empty", inj_c, 0);

    // Fully occupied network blocks; three valid inputs is enough to inject
    net_valid_i = 4'b1111;
    push_one(2'd2, 32'h11);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("blocked_c", inj_c, 0);
      tick();
    end
    net_valid_i = 4'b0111;
    settle();
    check("unblock_c", inj_c, exp_c(1, 2'd2));
    check("unblock_d", inj_d, 32'h11);
    tick();
    settle();
    check("unblock_empty", inj_c, 0);

    // Fill while blocked: DEPTH accepted, the extra flit waits for the first pop
    net_valid_i = 4'b1111;
    for (int i = 0; i <= DEPTH; i++) begin
      node_valid = 1'b1;
      node_dest  = 2'(i % 4);
      node_data  = 32'h100 + 32'(i);
      settle();
      check("fill_ready", node_ready, (i < DEPTH) ? 1 : 0);
      if (i < DEPTH) tick();
    end
    tick();
    check("full_hold_ready", node_ready, 0);
    check("full_hold_c", inj_c, 0);
    net_valid_i = 4'b0000;
    settle();
    check("full_pop_ready", node_ready, 0);
    check("full_pop_c", inj_c, exp_c(2, 2'd0));
    check("full_pop_d", inj_d, 32'h100);
    tick();
    check("after_pop_ready", node_ready, 1);
    check("pushpop_c", inj_c, exp_c(3, 2'd1));
    check("pushpop_d", inj_d, 32'h101);
    tick();
    node_valid = 1'b0;
    for (int i = 2; i <= DEPTH; i++) begin
      settle();
      check("drain_c", inj_c, exp_c(2 + i, 2'(i % 4)));
      check("drain_d", inj_d, 32'h100 + 32'(i));
      tick();
    end
    check("drain_empty", inj_c, 0);
    check("drain_ready", node_ready, 1);

    // Starvation: one flit blocked long enough to raise throttle_o
    net_valid_i = 4'b1111;
    push_one(2'd3, 32'hBEEF);
    for (int i = 0; i < 15; i++) tick();
    check("starve_pre", throttle_o, 0);
    tick();
`ifdef INJ_STARVE_EN
    check("starve_hi", throttle_o, 1);
`else
    check("starve_off", throttle_o, 0);
`endif
    net_valid_i = 4'b0000;
    settle();
    check("starve_inj_c", inj_c, exp_c(7, 2'd3));
    check("starve_inj_d", inj_d, 32'hBEEF);
    tick();
    check("starve_release", throttle_o, 0);
    check("starve_empty", inj_c, 0);

    // Nine streamed flits: sequence 0..7 then wraps to 0
    for (int i = 0; i <= 9; i++) begin
      node_valid = (i < 9);
      node_dest  = 2'(i % 4);
      node_data  = 32'h200 + 32'(i);
      settle();
      if (i > 0) begin
        check("seq_c", inj_c, exp_c((i - 1) % 8, 2'((i - 1) % 4)));
        check("seq_d", inj_d, 32'h200 + 32'(i - 1));
      end
      tick();
    end
    check("seq_empty", inj_c, 0);

    // Reset with three queued flits discards them and restarts seq
    net_valid_i = 4'b1111;
    for (int i = 0; i < 3; i++) push_one(2'd0, 32'h300 + 32'(i));
    rst = 1'b0;
    net_valid_i = 4'b0000;
    settle();
    check("midrst_c_now", inj_c, 0);
    tick();
    check("midrst_ready", node_ready, 1);
    check("midrst_c", inj_c, 0);
    check("midrst_d", inj_d, 0);
    check("midrst_throttle", throttle_o, 0);
    rst = 1'b1;
    settle();
    check("midrst_discard", inj_c, 0);
    push_one(2'd1, 32'h77);
    check("midrst_seq0_c", inj_c, exp_c(0, 2'd1));
    check("midrst_seq0_d", inj_d, 32'h77);
    tick();
    check("final_empty", inj_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bless_inject_ctrl.md
BLESS_INJECT_CTRL -- requirements
Module: bless_inject_ctrl

Interface
REQ-001 SHALL have parameter NODE_ADDR, default 2'b00: router address written into the src field of every injected flit.
REQ-002 SHALL have parameter DEPTH, default 4: injection queue depth, power of two, minimum 2.
REQ-003 SHALL have parameter STARVE_MAX, default 15: count of consecutive blocked cycles that declares starvation.
REQ-004 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock, synchronous, active-low.
REQ-006 SHALL have port node_valid  in  1  node offers a flit.
REQ-007 SHALL have port node_ready  out  1  queue accepts a flit.
REQ-008 SHALL have port node_dest  in  ADDR_W  destination address.
REQ-009 SHALL have port node_data  in  DATA_W  payload.
REQ-010 SHALL have port net_valid_i  in  4  valid bits of router network input ports 0-3 in the current cycle.
REQ-011 SHALL have port inj_c  out  CTRL_W  control word to router port 4.
REQ-012 SHALL have port inj_d  out  DATA_W  data word to router port 4.
REQ-013 SHALL have port throttle_o  out  1  starvation indication to the network.

Function
REQ-014 SHALL push {node_dest, node_data} when node_valid and node_ready are both 1; node_ready = !full, with no same-cycle pop credit when full.
REQ-015 SHALL compute free = (popcount(net_valid_i) < 4); inject = !empty & free, combinational from the registered queue head.
REQ-016 SHALL drive inj_c = {inject, seq_cnt, NODE_ADDR, head_dest, AGE_W'd0} and inj_d = head_data when inject = 1, and drive all-zero inj_c/inj_d otherwise.
REQ-017 SHALL pop the head and increment the SEQ_W-bit seq_cnt (modulo 2^SEQ_W, 7 wraps to 0) on every cycle with inject = 1.
REQ-018 SHALL have no empty bypass: a flit pushed at edge N is injectable no earlier than the cycle after edge N.
REQ-019 SHALL allow a simultaneous push and pop in a non-full, non-empty queue, leaving occupancy unchanged.
REQ-020 SHALL inject a flit with node_dest == NODE_ADDR like any other flit, with no special case.
REQ-021 SHALL implement FSM IDLE (queue empty), WAIT (non-empty), STARVED.
- IDLE->WAIT on push.
- WAIT->IDLE when the last flit is popped with no push.
- WAIT->STARVED when blk_cnt reaches STARVE_MAX.
- STARVED->WAIT (or IDLE if the queue drains) on the first inject.
REQ-022 SHALL clear blk_cnt on inject or when empty, increment it by 1 in any cycle with !empty & !free, and saturate it at STARVE_MAX.
REQ-023 SHALL register throttle_o = (state == STARVED), so it rises the cycle after blk_cnt reaches STARVE_MAX and falls the cycle after the releasing inject.

Reset
REQ-024 SHALL, while rst == 0 at an edge, clear the queue pointers and occupancy, seq_cnt, blk_cnt and throttle_o, and set state to IDLE.
REQ-025 SHALL during and after reset drive node_ready = 1 and inj_c = inj_d = 0; queued flits are discarded on reset mid-operation.

Configuration
REQ-026 SHALL, with INJ_STARVE_EN defined, include blk_cnt, the STARVED state and throttle_o as in REQ-021 to REQ-023.
REQ-027 SHALL, without INJ_STARVE_EN, omit blk_cnt and STARVED, and tie throttle_o to 0; the FSM is then IDLE/WAIT only and injection is unchanged.

Structure
REQ-028 SHALL place ADDR_W=2, SEQ_W=3, AGE_W=4, DATA_W=32, CTRL_W=1+SEQ_W+2*ADDR_W+AGE_W and the valid/seq/src/dest/age field offsets in the shared package bless_pkg, used by brouter and this block.
REQ-029 SHALL instantiate one sub-module, inj_fifo (synchronous DEPTH-entry FIFO with full/empty flags); the FSM, counters and control-word assembly stay in bless_inject_ctrl.

Verification
REQ-030 SHALL cover: reset, then push 1 flit (dest 1, data 0xA5) with net_valid_i = 4'b0000 -> inj_c valid exactly one cycle later, seq 0, src NODE_ADDR, age 0, inj_d 0xA5, queue empty after.
REQ-031 SHALL cover: net_valid_i = 4'b1111 with 1 queued flit -> no inject; the flit injects in the first cycle net_valid_i = 4'b0111.
REQ-032 SHALL cover: push DEPTH+1 flits back-to-back while blocked -> node_ready low after DEPTH pushes; the extra flit is held by the node and accepted only after the first pop.
REQ-033 SHALL cover: inject 9 flits -> seq sequence 0..7,0.
REQ-034 SHALL cover (INJ_STARVE_EN): 1 queued flit blocked 15 cycles -> throttle_o rises; 1 free cycle -> inject, and throttle_o falls the next cycle; without the macro, throttle_o stays 0.
REQ-035 SHALL cover: assert rst low with 3 queued flits -> next cycle node_ready = 1, inj_c = 0, and seq restarts at 0 on the next injection.
